keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, column-step (tick) rate in Hz; CLK_HZ/SCAN_HZ SHALL be >= 4.
REQ-003 SHALL have parameter DEBOUNCE_TICKS, default 16, number of consecutive stable ticks for press/release acceptance (range 2..255).
REQ-004 SHALL have parameter REPEAT_TICKS, default 250, auto-repeat period in ticks (used only with KEYPAD_AUTOREPEAT_EN).
REQ-005 Clk  input  1  system clock, all logic on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Row  input  4  keypad row sense, active-low, externally pulled up.
REQ-008 Col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-009 Key_Code  output  4  code of last accepted key, 4*column + row.
REQ-010 Key_Valid  output  1  one-Clk pulse per accepted press (and per repeat).
REQ-011 Key_Held  output  1  high while an accepted key remains pressed.

Function
REQ-012 Row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 A prescaler SHALL emit a one-Clk tick every CLK_HZ/SCAN_HZ cycles; synchronized Row is sampled only on tick.
REQ-014 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 SCAN: on tick, if sampled Row = 4'hF, advance column (0->1->2->3->0); else capture column and lowest-index low row, clear debounce count, go DEBOUNCE, column frozen.
REQ-016 DEBOUNCE: on tick, captured row low -> count+1; count reaching DEBOUNCE_TICKS-1 -> PRESSED; captured row high -> SCAN, count cleared, no output change.
REQ-017 Entry to PRESSED SHALL, in the same Clk, load Key_Code and assert Key_Valid for exactly one Clk; Key_Held goes high.
REQ-018 PRESSED: on tick with captured row high -> RELEASE, count cleared; additional rows pressed are ignored.
REQ-019 RELEASE: DEBOUNCE_TICKS consecutive high ticks -> SCAN, Key_Held low, column advances; any low tick -> PRESSED without new Key_Valid.
REQ-020 Key_Code SHALL hold its value until the next accepted press.
REQ-021 Multiple simultaneous rows in one column: lowest row index wins; keys in other columns are not seen until return to SCAN.
REQ-022 Prescaler and debounce counters SHALL wrap only by explicit clear; no overflow.

Reset
REQ-023 Reset low SHALL immediately force: state SCAN, Col=4'b1110, Key_Code=0, Key_Valid=0, Key_Held=0, counters 0, synchronizer 4'hF.
REQ-024 Reset asserted mid-press SHALL discard the press; after release of Reset a still-held key requires full debounce again.

Configuration
REQ-025 Macro KEYPAD_AUTOREPEAT_EN defined: in PRESSED, a repeat counter SHALL pulse Key_Valid (same Key_Code) every REPEAT_TICKS ticks after the initial press; counter cleared on leaving PRESSED.
REQ-026 Macro undefined: exactly one Key_Valid per press; no repeat logic synthesized.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum, the 4-bit code type and the column one-hot constants.
REQ-028 Prescaler SHALL be sub-module scan_tick_gen (params CLK_HZ, SCAN_HZ; ports Clk, Reset, Tick).

Verification (CLK_HZ=1000, SCAN_HZ=100 -> tick every 10 Clk, DEBOUNCE_TICKS=4, REPEAT_TICKS=8)
REQ-029 Reset release, no key -> Col cycles 1110,1101,1011,0111 every 10 Clk; Key_Valid never asserts.
REQ-030 Hold row 2 low while Col=1101, 100 Clk -> one Key_Valid pulse, Key_Code=6, Key_Held=1; release -> Key_Held=0 after 4 high ticks.
REQ-031 Row 1 low in column 3 for 2 ticks only (bounce) -> no Key_Valid, scanning resumes.
REQ-032 Rows 0 and 3 low in column 0 together -> Key_Code=0; single Key_Valid.
REQ-033 Reset pulsed low during DEBOUNCE -> outputs at reset values at once; held key re-accepted after 4 more ticks.
REQ-034 With KEYPAD_AUTOREPEAT_EN, key held 30 ticks -> Key_Valid at press then every 8 ticks (4 pulses total); without macro, 1 pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - scanner FSM states
//   key_code_t  - 4-bit key code, {column, row} == 4*column + row
//   COL0..COL3  - active-low one-hot column drive patterns
//   col_drive() - column index -> drive pattern
//   lowest_low()- index of the lowest-numbered low (pressed) row
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = COL0;
      2'd1:    col_drive = COL1;
      2'd2:    col_drive = COL2;
      default: col_drive = COL3;
    endcase
  endfunction

  // Caller guarantees at least one row is low; all-high falls to 3.
  function automatic logic [1:0] lowest_low(input logic [3:0] row);
    if      (!row[0]) lowest_low = 2'd0;
    else if (!row[1]) lowest_low = 2'd1;
    else if (!row[2]) lowest_low = 2'd2;
    else              lowest_low = 2'd3;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: prescaler producing a one-Clk Tick every CLK_HZ/SCAN_HZ
// cycles. The counter only returns to zero by its own explicit clear.
//   Clk   - system clock
//   Reset - asynchronous active-low reset
//   Tick  - one-cycle strobe
module scan_tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic Clk,
  input  logic Reset,
  output logic Tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 4) begin : g_bad_div
    $error("scan_tick_gen: CLK_HZ/SCAN_HZ must be >= 4");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign Tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
// Drives one column low at a time, samples the synchronized rows on each
// scan tick, debounces press and release, and reports accepted keys.
//   Clk       - system clock
//   Reset     - asynchronous active-low reset
//   Row       - row sense, active-low (pulled up externally)
//   Col       - column drive, active-low, exactly one bit low
//   Key_Code  - last accepted key, 4*column + row
//   Key_Valid - one-Clk pulse per accepted press (and per repeat)
//   Key_Held  - high while the accepted key stays pressed
// Optional build macro KEYPAD_AUTOREPEAT_EN: while held, re-pulse Key_Valid
// every REPEAT_TICKS ticks after the initial press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output key_code_t Key_Code,
  output logic      Key_Valid,
  output logic      Key_Held
);

  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 255) begin : g_bad_db
    $error("keypad_scanner: DEBOUNCE_TICKS must be 2..255");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_rep
    $error("keypad_scanner: REPEAT_TICKS must be >= 1");
  end

  // The detecting tick counts as the first of the DEBOUNCE_TICKS stable
  // ticks, so the counter finishes one short of DEBOUNCE_TICKS-1.
  localparam logic [7:0] DB_DONE = 8'(DEBOUNCE_TICKS - 2);

  logic [3:0] row_meta, row_sync;
  logic       tick;
  state_t     state, state_nxt;
  logic [1:0] col_idx, col_idx_nxt;
  logic [1:0] cap_row, cap_row_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept;
  logic       rep_fire;
  logic       cap_low;
  key_code_t  key_code;
  logic       key_valid;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= Row;
      row_sync <= row_meta;
    end
  end

  scan_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) u_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .Tick (tick)
  );

  assign cap_low = ~row_sync[cap_row];

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      cap_row <= 2'd0;
      cnt     <= 8'd0;
    end else begin
      state   <= state_nxt;
      col_idx <= col_idx_nxt;
      cap_row <= cap_row_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state logic; column stays frozen from capture until release done.
  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    cap_row_nxt = cap_row;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (row_sync == 4'hF) begin
            col_idx_nxt = col_idx + 2'd1;
          end else begin
            cap_row_nxt = lowest_low(row_sync);
            cnt_nxt     = 8'd0;
            state_nxt   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!cap_low) begin
            cnt_nxt   = 8'd0;
            state_nxt = SCAN;
          end else if (cnt == DB_DONE) begin
            cnt_nxt   = 8'd0;
            state_nxt = PRESSED;
            accept    = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        PRESSED: begin
          if (!cap_low) begin
            cnt_nxt   = 8'd0;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (cap_low) begin
            cnt_nxt   = 8'd0;
            state_nxt = PRESSED;
          end else if (cnt == DB_DONE) begin
            cnt_nxt     = 8'd0;
            state_nxt   = SCAN;
            col_idx_nxt = col_idx + 2'd1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt;

  // Counts low ticks spent in PRESSED; the tick that returns from RELEASE
  // is spent in RELEASE, so a bounce restarts the period.
  assign rep_fire = (state == PRESSED) && tick && cap_low && (rep_cnt == REP_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                   rep_cnt <= '0;
    else if (state != PRESSED)    rep_cnt <= '0;
    else if (tick && cap_low)     rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Key_Code and Key_Valid update on the same edge that enters PRESSED.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept | rep_fire;
      if (accept) key_code <= {col_idx, cap_row};
    end
  end

  // Outputs
  always_comb begin
    Col       = col_drive(col_idx);
    Key_Code  = key_code;
    Key_Valid = key_valid;
    Key_Held  = (state == PRESSED) || (state == RELEASE);
  end

endmodule
